// File: rtl/ibex_mem_arbiter.sv
// Arbitrates the Ibex instruction-fetch and load/store ports onto one shared memory port.
// Grants alternate between the two sources, and read responses are routed back in order.
module ibex_mem_arbiter #(
    parameter int unsigned MaxOutstanding = 2,
    parameter bit          DataFirst      = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,

    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,

    output logic        busy_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    typedef enum logic [1:0] {
        LOCK_NONE  = 2'd0,
        LOCK_INSTR = 2'd1,
        LOCK_DATA  = 2'd2
    } lock_e;

    lock_e                     lock_q, lock_d;
    logic                      ptr_q, ptr_d;
    logic [CntW-1:0]           count_q, count_d;
    logic [MaxOutstanding-1:0] fifo_q, fifo_d;

    logic            full;
    logic            sel_data;
    logic            sel_valid;
    logic            push;
    logic            pop;
    logic [CntW-1:0] widx;

    // Source selection: a stalled request keeps ownership, otherwise round-robin.
    always_comb begin
        full = (count_q == CntW'(MaxOutstanding));
        if (lock_q == LOCK_INSTR && instr_req_i) begin
            sel_data = 1'b0;
        end else if (lock_q == LOCK_DATA && data_req_i) begin
            sel_data = 1'b1;
        end else if (instr_req_i && data_req_i) begin
            sel_data = ptr_q;
        end else begin
            sel_data = data_req_i;
        end
        sel_valid = (instr_req_i || data_req_i) && !full;
    end

    assign push = sel_valid && mem_gnt_i;
    assign pop  = mem_rvalid_i && (count_q != '0);

    // Request path towards memory.
    always_comb begin
        mem_req_o   = sel_valid;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;
        if (sel_valid) begin
            if (sel_data) begin
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_addr_o  = data_addr_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                mem_be_o    = 4'hF;
                mem_addr_o  = instr_addr_i;
            end
        end
    end

    assign instr_gnt_o    = push && !sel_data;
    assign data_gnt_o     = push && sel_data;

    // Responses follow the head entry as it was before any same-cycle push.
    assign instr_rvalid_o = pop && !fifo_q[0];
    assign data_rvalid_o  = pop && fifo_q[0];
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign instr_err_o    = mem_err_i;
    assign data_err_o     = mem_err_i;

    assign busy_o         = (count_q != '0);

    // Next-state logic for lock, pointer and source FIFO.
    always_comb begin
        lock_d  = LOCK_NONE;
        ptr_d   = ptr_q;
        count_d = count_q;
        fifo_d  = fifo_q;
        widx    = count_q;

        if (push) begin
            lock_d = LOCK_NONE;
        end else if (sel_valid) begin
            lock_d = sel_data ? LOCK_DATA : LOCK_INSTR;
        end else if (lock_q == LOCK_INSTR && instr_req_i) begin
            lock_d = LOCK_INSTR;
        end else if (lock_q == LOCK_DATA && data_req_i) begin
            lock_d = LOCK_DATA;
        end

        if (push) begin
            ptr_d = !sel_data;
        end

        if (pop) begin
            fifo_d = fifo_q >> 1;
            widx   = count_q - CntW'(1);
        end
        for (int unsigned i = 0; i < MaxOutstanding; i++) begin
            if (push && widx == CntW'(i)) begin
                fifo_d[i] = sel_data;
            end
        end

        count_d = count_q + CntW'(push) - CntW'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q  <= LOCK_NONE;
            ptr_q   <= DataFirst;
            count_q <= '0;
            fifo_q  <= '0;
        end else begin
            lock_q  <= lock_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            fifo_q  <= fifo_d;
        end
    end

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Directed test of ibex_mem_arbiter: round-robin, stall lock, outstanding limit,
// same-cycle grant and response, spurious responses and reset mid-operation.
module tb_ibex_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i, data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
    logic [31:0] mem_rdata_i;
    logic        busy_o;

    int n_cmp = 0;
    int n_err = 0;

    ibex_mem_arbiter #(.MaxOutstanding(2), .DataFirst(1'b1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        instr_req_i  = 1'b0;
        instr_addr_i = 32'h0000_1000;
        data_req_i   = 1'b0;
        data_we_i    = 1'b1;
        data_be_i    = 4'h3;
        data_addr_i  = 32'h0000_2000;
        data_wdata_i = 32'hDEAD_BEEF;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
        mem_err_i    = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_ni = 1'b0;
        settle();
        n_cmp++;
        if ({busy_o, instr_rvalid_o, data_rvalid_o, mem_req_o} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_idle: busy/irv/drv/req got %b want 0000",
                     {busy_o, instr_rvalid_o, data_rvalid_o, mem_req_o});
        end
        n_cmp++;
        if ({mem_addr_o, mem_wdata_o, mem_be_o, mem_we_o} !== 69'h0) begin
            n_err++;
            $display("FAIL reset_zero_bus: addr=%h wdata=%h be=%h we=%b want all 0",
                     mem_addr_o, mem_wdata_o, mem_be_o, mem_we_o);
        end
        // Request path stays live during reset.
        instr_req_i = 1'b1;
        settle();
        n_cmp++;
        if ({mem_req_o, mem_addr_o, mem_be_o} !== {1'b1, 32'h0000_1000, 4'hF}) begin
            n_err++;
            $display("FAIL reset_req_path: req=%b addr=%h be=%h want 1 00001000 f",
                     mem_req_o, mem_addr_o, mem_be_o);
        end
        tick();
        rst_ni = 1'b1;
        clear_inputs();
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        instr_req_i = 1'b1;
        data_req_i  = 1'b1;
        mem_gnt_i   = 1'b1;
        settle();
        n_cmp++;
        if ({instr_gnt_o, data_gnt_o} !== 2'b01 || mem_addr_o !== 32'h0000_2000
            || mem_we_o !== 1'b1 || mem_be_o !== 4'h3 || mem_wdata_o !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL rr_c0_data: ig/dg=%b addr=%h we=%b be=%h wd=%h want 01 00002000 1 3 deadbeef",
                     {instr_gnt_o, data_gnt_o}, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o);
        end
        tick();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hA;
        settle();
        n_cmp++;
        if ({instr_gnt_o, data_gnt_o} !== 2'b10 || mem_addr_o !== 32'h0000_1000
            || mem_we_o !== 1'b0 || mem_be_o !== 4'hF || mem_wdata_o !== 32'h0) begin
            n_err++;
            $display("FAIL rr_c1_instr: ig/dg=%b addr=%h we=%b be=%h wd=%h want 10 00001000 0 f 0",
                     {instr_gnt_o, data_gnt_o}, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o);
        end
        n_cmp++;
        if ({instr_rvalid_o, data_rvalid_o} !== 2'b01 || data_rdata_o !== 32'hA) begin
            n_err++;
            $display("FAIL rr_resp_a: irv/drv=%b drdata=%h want 01 a",
                     {instr_rvalid_o, data_rvalid_o}, data_rdata_o);
        end
        tick();
        mem_rdata_i = 32'hB;
        settle();
        n_cmp++;
        if ({instr_gnt_o, data_gnt_o} !== 2'b01 || {instr_rvalid_o, data_rvalid_o} !== 2'b10
            || instr_rdata_o !== 32'hB || busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL rr_c2_data_resp_b: gnt=%b rv=%b irdata=%h busy=%b want 01 10 b 1",
                     {instr_gnt_o, data_gnt_o}, {instr_rvalid_o, data_rvalid_o},
                     instr_rdata_o, busy_o);
        end
        tick();
        instr_req_i = 1'b0;
        data_req_i  = 1'b0;
        mem_rdata_i = 32'hC;
        mem_err_i   = 1'b1;
        settle();
        n_cmp++;
        if ({instr_rvalid_o, data_rvalid_o} !== 2'b01 || data_rdata_o !== 32'hC
            || {instr_err_o, data_err_o} !== 2'b11 || mem_req_o !== 1'b0) begin
            n_err++;
            $display("FAIL rr_resp_c: rv=%b drdata=%h err=%b req=%b want 01 c 11 0",
                     {instr_rvalid_o, data_rvalid_o}, data_rdata_o,
                     {instr_err_o, data_err_o}, mem_req_o);
        end
        tick();
        clear_inputs();
        settle();
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL rr_drained_busy: got %b want 0", busy_o);
        end
    endtask

    task automatic test_lock();
        do_reset();
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_1234;
        settle();
        for (int c = 1; c <= 3; c++) begin
            n_cmp++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0000_1234
                || {instr_gnt_o, data_gnt_o} !== 2'b00) begin
                n_err++;
                $display("FAIL lock_hold_c%0d: req=%b addr=%h gnt=%b want 1 00001234 00",
                         c, mem_req_o, mem_addr_o, {instr_gnt_o, data_gnt_o});
            end
            tick();
            data_req_i = 1'b1;
            settle();
        end
        mem_gnt_i = 1'b1;
        settle();
        n_cmp++;
        if ({instr_gnt_o, data_gnt_o} !== 2'b10 || mem_addr_o !== 32'h0000_1234) begin
            n_err++;
            $display("FAIL lock_grant_c4: gnt=%b addr=%h want 10 00001234",
                     {instr_gnt_o, data_gnt_o}, mem_addr_o);
        end
        tick();
        instr_req_i = 1'b0;
        settle();
        n_cmp++;
        if ({instr_gnt_o, data_gnt_o} !== 2'b01 || mem_addr_o !== 32'h0000_2000) begin
            n_err++;
            $display("FAIL lock_then_data: gnt=%b addr=%h want 01 00002000",
                     {instr_gnt_o, data_gnt_o}, mem_addr_o);
        end
        tick();
        data_req_i   = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        settle();
        n_cmp++;
        if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin
            n_err++;
            $display("FAIL lock_resp1: rv=%b want 10", {instr_rvalid_o, data_rvalid_o});
        end
        tick();
        settle();
        n_cmp++;
        if ({instr_rvalid_o, data_rvalid_o} !== 2'b01) begin
            n_err++;
            $display("FAIL lock_resp2: rv=%b want 01", {instr_rvalid_o, data_rvalid_o});
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_max_outstanding();
        do_reset();
        data_req_i = 1'b1;
        mem_gnt_i  = 1'b1;
        tick();
        tick();
        settle();
        n_cmp++;
        if ({mem_req_o, instr_gnt_o, data_gnt_o} !== 3'b000 || mem_addr_o !== 32'h0
            || busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL full_block: req/ig/dg=%b addr=%h busy=%b want 000 0 1",
                     {mem_req_o, instr_gnt_o, data_gnt_o}, mem_addr_o, busy_o);
        end
        mem_rvalid_i = 1'b1;
        settle();
        n_cmp++;
        if ({mem_req_o, instr_gnt_o, data_gnt_o} !== 3'b000 || data_rvalid_o !== 1'b1) begin
            n_err++;
            $display("FAIL full_pop_still_blocks: req/ig/dg=%b drv=%b want 000 1",
                     {mem_req_o, instr_gnt_o, data_gnt_o}, data_rvalid_o);
        end
        tick();
        mem_rvalid_i = 1'b0;
        settle();
        n_cmp++;
        if ({mem_req_o, data_gnt_o} !== 2'b11) begin
            n_err++;
            $display("FAIL full_regrant: req/dg=%b want 11", {mem_req_o, data_gnt_o});
        end
        tick();
        data_req_i   = 1'b0;
        mem_rvalid_i = 1'b1;
        tick();
        tick();
        mem_rvalid_i = 1'b0;
        settle();
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL full_drain_busy: got %b want 0", busy_o);
        end
        clear_inputs();
    endtask

    task automatic test_spurious();
        do_reset();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h5555_AAAA;
        settle();
        n_cmp++;
        if ({instr_rvalid_o, data_rvalid_o, busy_o} !== 3'b000) begin
            n_err++;
            $display("FAIL spur_rvalid: irv/drv/busy=%b want 000",
                     {instr_rvalid_o, data_rvalid_o, busy_o});
        end
        tick();
        mem_rvalid_i = 1'b0;
        settle();
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL spur_busy_after: got %b want 0", busy_o);
        end
        instr_req_i = 1'b1;
        mem_gnt_i   = 1'b1;
        tick();
        clear_inputs();
        mem_rvalid_i = 1'b1;
        settle();
        n_cmp++;
        if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin
            n_err++;
            $display("FAIL spur_next_resp: rv=%b want 10", {instr_rvalid_o, data_rvalid_o});
        end
        tick();
        settle();
        n_cmp++;
        if ({instr_rvalid_o, data_rvalid_o, busy_o} !== 3'b000) begin
            n_err++;
            $display("FAIL spur_count_zero: irv/drv/busy=%b want 000",
                     {instr_rvalid_o, data_rvalid_o, busy_o});
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        data_req_i = 1'b1;
        mem_gnt_i  = 1'b1;
        tick();
        tick();
        clear_inputs();
        settle();
        n_cmp++;
        if (busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_busy_before: got %b want 1", busy_o);
        end
        rst_ni = 1'b0;
        #1;
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_busy_async: got %b want 0", busy_o);
        end
        tick();
        rst_ni = 1'b1;
        mem_rvalid_i = 1'b1;
        settle();
        n_cmp++;
        if ({instr_rvalid_o, data_rvalid_o, busy_o} !== 3'b000) begin
            n_err++;
            $display("FAIL rstmid_stale_resp: irv/drv/busy=%b want 000",
                     {instr_rvalid_o, data_rvalid_o, busy_o});
        end
        tick();
        mem_rvalid_i = 1'b0;
        instr_req_i  = 1'b1;
        data_req_i   = 1'b1;
        mem_gnt_i    = 1'b1;
        settle();
        n_cmp++;
        if ({instr_gnt_o, data_gnt_o} !== 2'b01) begin
            n_err++;
            $display("FAIL rstmid_ptr_data: gnt=%b want 01", {instr_gnt_o, data_gnt_o});
        end
        tick();
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst_ni = 1'b0;
        test_reset();
        test_round_robin();
        test_lock();
        test_max_outstanding();
        test_spurious();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ibex_mem_arbiter.md
IBEX_MEM_ARBITER -- requirements
Module: ibex_mem_arbiter

Interface
REQ-001 SHALL have parameter MaxOutstanding, default 2: maximum granted-but-unanswered memory transactions, legal range 1..8.
REQ-002 SHALL have parameter DataFirst, default 1'b1: requester given priority after reset (1 = data, 0 = instr).
REQ-003 SHALL have one clock, clk_i; reset is asynchronous and active-low, rst_ni.
REQ-004 clk_i  in  1  core clock; all state updates on rising edge.
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 instr_req_i  in  1  instruction fetch request, held until instr_gnt_o.
REQ-007 instr_addr_i  in  32  fetch address.
REQ-008 instr_gnt_o  out  1  fetch request accepted this cycle.
REQ-009 instr_rvalid_o  out  1  fetch response valid.
REQ-010 instr_rdata_o  out  32  fetch read data; instr_err_o  out  1  fetch bus error.
REQ-011 data_req_i  in  1  load/store request, held until data_gnt_o.
REQ-012 data_we_i  in  1  write enable; data_be_i  in  4  byte enables; data_addr_i  in  32  address; data_wdata_i  in  32  write data.
REQ-013 data_gnt_o  out  1  load/store accepted; data_rvalid_o  out  1  response valid; data_rdata_o  out  32  read data; data_err_o  out  1  bus error.
REQ-014 mem_req_o  out  1; mem_we_o  out  1; mem_be_o  out  4; mem_addr_o  out  32; mem_wdata_o  out  32  shared memory request port.
REQ-015 mem_gnt_i  in  1; mem_rvalid_i  in  1; mem_rdata_i  in  32; mem_err_i  in  1  shared memory response port; responses arrive in order, earliest one cycle after grant.
REQ-016 busy_o  out  1  high while at least one transaction is outstanding.

Function
REQ-017 SHALL keep an in-order source FIFO (1 bit per entry: 0 = instr, 1 = data), depth MaxOutstanding, with a count register.
REQ-018 SHALL push the granted source when mem_req_o && mem_gnt_i, and pop the head when mem_rvalid_i && count != 0; simultaneous push and pop leaves count unchanged with correct ordering.
REQ-019 SHALL assert mem_req_o combinationally when (instr_req_i || data_req_i) && count < MaxOutstanding; when count == MaxOutstanding, mem_req_o, instr_gnt_o and data_gnt_o SHALL be 0, even if a pop happens in the same cycle.
REQ-020 Selection when unlocked and both requesting: the source holding the round-robin pointer wins; with a single requester, that requester wins.
REQ-021 After each grant, the pointer SHALL move to the other source; after reset it SHALL point to data if DataFirst, else instr.
REQ-022 Lock: if mem_req_o && !mem_gnt_i, the same source SHALL stay selected next cycle regardless of the pointer, while that source's req stays high; the lock clears on grant or when that req drops.
REQ-023 Instr selected: mem_addr_o = instr_addr_i, mem_we_o = 0, mem_be_o = 4'hF, mem_wdata_o = 0.
REQ-024 Data selected: mem_addr_o/we/be/wdata SHALL equal the data_* inputs.
REQ-025 No source selected: mem_addr_o/we/be/wdata SHALL be 0.
REQ-026 instr_gnt_o = mem_gnt_i && mem_req_o && selected == instr; data_gnt_o likewise for data; at most one gnt is high per cycle.
REQ-027 instr_rvalid_o = mem_rvalid_i && count != 0 && head == instr; data_rvalid_o likewise for data; zero-latency combinational routing.
REQ-028 mem_rdata_i and mem_err_i SHALL be forwarded unmodified to both *_rdata_o and both *_err_o.
REQ-029 mem_rvalid_i with count == 0 is spurious: SHALL be ignored, with no rvalid output and no state change.
REQ-030 A grant and a response in the same cycle SHALL route the response by the pre-push head.
REQ-031 busy_o SHALL be registered-state derived: (count != 0).

Reset
REQ-032 While rst_ni is low: count = 0, FIFO cleared, lock cleared, pointer = DataFirst.
REQ-033 Reset values: busy_o = 0, instr_rvalid_o = 0, data_rvalid_o = 0; request-path outputs follow inputs per REQ-019..026.
REQ-034 Reset mid-operation SHALL discard all outstanding entries; responses arriving after reset release are spurious per REQ-029.

Verification
REQ-035 Both req high at once, after reset, DataFirst = 1, mem_gnt_i = 1 -> data granted cycle 0, instr cycle 1, data cycle 2 (alternating); responses 0xA, 0xB, 0xC land on data, instr, data in order.
REQ-036 Instr req, mem_gnt_i low for 3 cycles while data_req_i rises -> instr stays selected with stable addr; instr_gnt_o on cycle 4; data granted next.
REQ-037 MaxOutstanding = 2, two grants, no rvalid -> mem_req_o = 0 and gnts = 0; an rvalid in that cycle still blocks grants; the next cycle grants again.
REQ-038 Grant and rvalid in the same cycle with count = 1 -> the response goes to the old head; count stays 1; busy_o stays 1.
REQ-039 mem_rvalid_i pulse with count = 0 -> both rvalid outputs 0, count stays 0, busy_o = 0.
REQ-040 rst_ni pulsed low with 2 outstanding -> busy_o = 0 immediately; later mem_rvalid_i is ignored; pointer returns to data.
